// File: rtl/e_mdu_if.sv
// E-stage multiply/divide unit port bundle: control decode, forwarded operands, busy and read data.
// The cancel signal exists only when MDU_CANCEL_EN is defined.
interface e_mdu_if;
  logic        start;
  logic [2:0]  HILOOP;
  logic [1:0]  WHILO;
  logic [1:0]  HILOSel_E;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HILO_out;
  logic        dbg_run;
`ifdef MDU_CANCEL_EN
  logic        cancel;

  modport master (output start, HILOOP, WHILO, HILOSel_E, A, B, cancel,
                  input  busy, HILO_out, dbg_run);
  modport slave  (input  start, HILOOP, WHILO, HILOSel_E, A, B, cancel,
                  output busy, HILO_out, dbg_run);
`else
  modport master (output start, HILOOP, WHILO, HILOSel_E, A, B,
                  input  busy, HILO_out, dbg_run);
  modport slave  (input  start, HILOOP, WHILO, HILOSel_E, A, B,
                  output busy, HILO_out, dbg_run);
`endif
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Optional feature macro: MDU_CANCEL_EN (adds a cancel input that aborts/suppresses operations).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave mdu
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic             commit_ok_q, commit_ok_d;
  logic             cancel;

`ifdef MDU_CANCEL_EN
  assign cancel = mdu.cancel;
`else
  assign cancel = 1'b0;
`endif

  // Result datapath, evaluated from the current operands in the launch cycle.
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;
  logic        signed_div;

  assign prod_s     = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
  assign prod_u     = {32'd0, mdu.A} * {32'd0, mdu.B};
  assign signed_div = ~mdu.HILOOP[0];
  // Divide on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
  assign dvd      = (signed_div && mdu.A[31]) ? (~mdu.A + 32'd1) : mdu.A;
  assign dvs      = (signed_div && mdu.B[31]) ? (~mdu.B + 32'd1) : mdu.B;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q_mag    = dvd / dvs_safe;
  assign r_mag    = dvd % dvs_safe;
  assign quot     = (signed_div && (mdu.A[31] ^ mdu.B[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = (signed_div && mdu.A[31]) ? (~r_mag + 32'd1) : r_mag;

  logic launch, mt_ok;
  assign launch = (state_q == ST_IDLE) && mdu.start && !mdu.HILOOP[2] && !cancel;
  assign mt_ok  = (state_q == ST_IDLE) && !mdu.start && !cancel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    tmp_hi_d    = tmp_hi_q;
    tmp_lo_d    = tmp_lo_q;
    commit_ok_d = commit_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_RUN;
          if (mdu.HILOOP[1]) begin
            {tmp_hi_d, tmp_lo_d} = {rem, quot};
            cnt_d                = CNT_W'(DIV_CYCLES);
            commit_ok_d          = (mdu.B != 32'd0);
          end else begin
            {tmp_hi_d, tmp_lo_d} = mdu.HILOOP[0] ? prod_u : prod_s;
            cnt_d                = CNT_W'(MULT_CYCLES);
            commit_ok_d          = 1'b1;
          end
        end else if (mt_ok) begin
          if (mdu.WHILO == 2'b00) hi_d = mdu.A;
          if (mdu.WHILO == 2'b01) lo_d = mdu.A;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (commit_ok_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      tmp_hi_q    <= '0;
      tmp_lo_q    <= '0;
      commit_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      tmp_hi_q    <= tmp_hi_d;
      tmp_lo_q    <= tmp_lo_d;
      commit_ok_q <= commit_ok_d;
    end
  end

  assign mdu.busy    = (state_q == ST_RUN);
  assign mdu.dbg_run = state_q[0];

  always_comb begin
    case (mdu.HILOSel_E)
      2'b00:   mdu.HILO_out = hi_q;
      2'b01:   mdu.HILO_out = lo_q;
      default: mdu.HILO_out = 32'd0;
    endcase
  end

endmodule
